// File: rtl/rnn_pkg.sv
// Shared definitions for the denoise RNN datapath: layer indices, scheduler
// states and the mapping from GRU layers to their state-latch strobe bits.
package rnn_pkg;

  localparam int FIXED = 32;

  localparam logic [2:0] L_DENSE1 = 3'd0;
  localparam logic [2:0] L_GRU1   = 3'd1;
  localparam logic [2:0] L_DENSE2 = 3'd2;
  localparam logic [2:0] L_GRU2   = 3'd3;
  localparam logic [2:0] L_GRU3   = 3'd4;
  localparam logic [2:0] L_DENSE3 = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2,
    S_ERR  = 2'd3
  } sched_state_e;

  // Strobe mask raised when layer k completes: gru1->vad, gru2->noise, gru3->denoise.
  function automatic logic [2:0] gru_latch_mask(input logic [2:0] k);
    case (k)
      L_GRU1:  return 3'b001;
      L_GRU2:  return 3'b010;
      L_GRU3:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/rnn_layer_watchdog.sv
// Saturating up-counter with synchronous clear and enable; hit_o flags the last
// cycle before LIMIT cycles have elapsed (LIMIT=0 disables the compare).
module rnn_layer_watchdog #(
  parameter int CNT_W = 16,
  parameter int LIMIT = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             hit_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] HIT_AT  = CNT_W'(LIMIT > 0 ? LIMIT - 1 : 0);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign hit_o   = (LIMIT != 0) && (count_q == HIT_AT);

endmodule

// File: rtl/rnn_layer_scheduler.sv
// Frame sequencer: runs the six layer engines in order, strobes GRU state
// latches, and aborts to ERR when a layer exceeds its watchdog budget.
module rnn_layer_scheduler
  import rnn_pkg::*;
#(
  parameter int NUM_LAYERS     = 6,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16,
  parameter int FRAME_CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   clear_state,
  input  logic [NUM_LAYERS-1:0]  layer_valid,
  output logic [NUM_LAYERS-1:0]  layer_start,
  output logic [2:0]             state_latch,
  output logic                   state_clear,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   error,
  output logic [2:0]             err_layer,
  output logic [CNT_W-1:0]       frame_cycles,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output sched_state_e           dbg_state
);

  localparam logic [2:0] LAST = 3'(NUM_LAYERS - 1);

  sched_state_e           state_q, state_d;
  logic [2:0]             k_q, k_d;
  logic                   pending_q, pending_d;
  logic                   error_q, error_d;
  logic [2:0]             err_layer_q, err_layer_d;
  logic [2:0]             latch_q, latch_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       fcycles_q, fcycles_d;
  logic [FRAME_CNT_W-1:0] fcount_q, fcount_d;

  logic             run, accept, wd_hit, fc_hit_unused;
  logic [CNT_W-1:0] wd_count_unused, fc_count;

  // Handshake: layer_start[k] is a level held while the scheduler is in RUN k;
  // the engine answers with a one-cycle layer_valid[k], accepted on that edge,
  // after which start[k] falls and start[k+1] rises on the next cycle.
  assign run    = (state_q == S_RUN);
  assign accept = run && layer_valid[k_q];

  rnn_layer_watchdog #(.CNT_W(CNT_W), .LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (!run || accept),
    .en_i    (run),
    .count_o (wd_count_unused),
    .hit_o   (wd_hit)
  );

  rnn_layer_watchdog #(.CNT_W(CNT_W), .LIMIT(0)) u_frame_timer (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (!run),
    .en_i    (run),
    .count_o (fc_count),
    .hit_o   (fc_hit_unused)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    pending_d   = pending_q;
    error_d     = error_q;
    err_layer_d = err_layer_q;
    latch_d     = '0;
    done_d      = 1'b0;
    fcycles_d   = fcycles_q;
    fcount_d    = fcount_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (clear_state) begin
          state_d     = S_CLR;
          pending_d   = frame_start;
          error_d     = 1'b0;
          err_layer_d = '0;
        end else if (frame_start) begin
          state_d     = S_RUN;
          k_d         = '0;
          error_d     = 1'b0;
          err_layer_d = '0;
        end
      end
      S_CLR: begin
        pending_d = 1'b0;
        k_d       = '0;
        state_d   = pending_q ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        // A valid in the watchdog's final cycle still counts as completion.
        if (accept) begin
          latch_d = gru_latch_mask(k_q);
          if (k_q == LAST) begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            fcount_d  = fcount_q + FRAME_CNT_W'(1);
            fcycles_d = (&fc_count) ? fc_count : fc_count + CNT_W'(1);
          end else begin
            k_d = k_q + 3'd1;
          end
        end else if (wd_hit) begin
          state_d     = S_ERR;
          error_d     = 1'b1;
          err_layer_d = k_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      pending_q   <= 1'b0;
      error_q     <= 1'b0;
      err_layer_q <= '0;
      latch_q     <= '0;
      done_q      <= 1'b0;
      fcycles_q   <= '0;
      fcount_q    <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      pending_q   <= pending_d;
      error_q     <= error_d;
      err_layer_q <= err_layer_d;
      latch_q     <= latch_d;
      done_q      <= done_d;
      fcycles_q   <= fcycles_d;
      fcount_q    <= fcount_d;
    end
  end

  assign layer_start  = run ? (NUM_LAYERS'(1) << k_q) : '0;
  assign state_latch  = latch_q;
  assign state_clear  = (state_q == S_CLR);
  assign busy         = run;
  assign frame_done   = done_q;
  assign error        = error_q;
  assign err_layer    = err_layer_q;
  assign frame_cycles = fcycles_q;
  assign frame_count  = fcount_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_rnn_layer_scheduler.sv
// Directed bench for the layer scheduler: engine responder tasks, frame-result
// scoreboard, watchdog/reset/wrap scenarios.
module tb_rnn_layer_scheduler;

  localparam int TO  = 20;
  localparam int CW  = 5;
  localparam int FCW = 4;
  localparam int CYC_MAX = 31;

  logic           clk;
  logic           rst;
  logic           frame_start;
  logic           clear_state;
  logic [5:0]     layer_valid;
  logic [5:0]     layer_start;
  logic [2:0]     state_latch;
  logic           state_clear;
  logic           busy;
  logic           frame_done;
  logic           error;
  logic [2:0]     err_layer;
  logic [CW-1:0]  frame_cycles;
  logic [FCW-1:0] frame_count;
  rnn_pkg::sched_state_e dbg_state;

  int checks = 0;
  int errors = 0;
  logic [CW+FCW-1:0] exp_q[$];
  logic [FCW-1:0]    exp_frames;
  logic [CW-1:0]     last_cyc;

  rnn_layer_scheduler #(
    .NUM_LAYERS(6), .TIMEOUT_CYCLES(TO), .CNT_W(CW), .FRAME_CNT_W(FCW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .clear_state  (clear_state),
    .layer_valid  (layer_valid),
    .layer_start  (layer_start),
    .state_latch  (state_latch),
    .state_clear  (state_clear),
    .busy         (busy),
    .frame_done   (frame_done),
    .error        (error),
    .err_layer    (err_layer),
    .frame_cycles (frame_cycles),
    .frame_count  (frame_count),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_latch(input int k);
    case (k)
      1:       return 3'b001;
      3:       return 3'b010;
      4:       return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, 32'(layer_start), 32'd0);
    chk({tag, "_latch"}, 32'(state_latch), 32'd0);
    chk({tag, "_clear"}, 32'(state_clear), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(frame_done), 32'd0);
    chk({tag, "_err"},   32'(error), 32'd0);
    chk({tag, "_errl"},  32'(err_layer), 32'd0);
    chk({tag, "_fcyc"},  32'(frame_cycles), 32'd0);
    chk({tag, "_fcnt"},  32'(frame_count), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(rnn_pkg::S_IDLE));
  endtask

  // driver: request a frame; returns at the negedge of the first start[0] cycle
  task automatic launch(input bit clr);
    frame_start = 1'b1;
    clear_state = clr;
    @(negedge clk);
    frame_start = 1'b0;
    clear_state = 1'b0;
    chk("launch_err", 32'(error), 32'd0);
    chk("launch_errl", 32'(err_layer), 32'd0);
    if (clr) begin
      chk("clr_strobe", 32'(state_clear), 32'd1);
      chk("clr_nostart", 32'(layer_start), 32'd0);
      @(negedge clk);
      chk("clr_drop", 32'(state_clear), 32'd0);
    end
  endtask

  // driver: engine k answers d cycles after its start rises
  task automatic serve_layer(input int k, input int d, input bit poke, input bit spur);
    logic [CW+FCW-1:0] e;
    chk("start_on", 32'(layer_start), 32'(1) << k);
    chk("busy_on", 32'(busy), 32'd1);
    if (poke) begin
      frame_start = 1'b1;
      clear_state = 1'b1;
    end
    if (spur) layer_valid = 6'b010000;
    for (int i = 1; i <= d; i++) begin
      @(negedge clk);
      frame_start = 1'b0;
      clear_state = 1'b0;
      layer_valid = '0;
      chk("start_hold", 32'(layer_start), 32'(1) << k);
      chk("latch_quiet", 32'(state_latch), 32'd0);
      chk("clear_quiet", 32'(state_clear), 32'd0);
    end
    layer_valid[k] = 1'b1;
    @(negedge clk);
    layer_valid = '0;
    chk("latch_strobe", 32'(state_latch), 32'(exp_latch(k)));
    if (k == 5) begin
      chk("done_pulse", 32'(frame_done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_start", 32'(layer_start), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow observed=frame_done expected=no_frame");
      end else begin
        e = exp_q.pop_front();
        chk("frame_cycles", 32'(frame_cycles), 32'(e[CW+FCW-1:FCW]));
        chk("frame_count", 32'(frame_count), 32'(e[FCW-1:0]));
      end
    end else begin
      chk("no_done", 32'(frame_done), 32'd0);
    end
  endtask

  task automatic run_frame(input int d, input int poke_k, input int spur_k, input bit clr);
    int cyc;
    cyc = 6 * (d + 1);
    if (cyc > CYC_MAX) cyc = CYC_MAX;
    exp_frames = exp_frames + 4'd1;
    last_cyc   = CW'(cyc);
    exp_q.push_back({CW'(cyc), exp_frames});
    launch(clr);
    for (int k = 0; k < 6; k++) serve_layer(k, d, (k == poke_k), (k == spur_k));
    @(negedge clk);
    chk("post_done", 32'(frame_done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_start", 32'(layer_start), 32'd0);
    chk("post_err", 32'(error), 32'd0);
  endtask

  task automatic do_timeout(input int kb);
    launch(1'b0);
    for (int k = 0; k < kb; k++) serve_layer(k, 1, 1'b0, 1'b0);
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      chk("wd_not_yet", 32'(error), 32'd0);
      chk("wd_hold", 32'(layer_start), 32'(1) << kb);
    end
    @(negedge clk);
    chk("wd_error", 32'(error), 32'd1);
    chk("wd_layer", 32'(err_layer), 32'(kb));
    chk("wd_start", 32'(layer_start), 32'd0);
    chk("wd_busy", 32'(busy), 32'd0);
    chk("wd_state", 32'(dbg_state), 32'(rnn_pkg::S_ERR));
    @(negedge clk);
    chk("wd_sticky", 32'(error), 32'd1);
    chk("wd_fcyc", 32'(frame_cycles), 32'(last_cyc));
    chk("wd_fcnt", 32'(frame_count), 32'(exp_frames));
  endtask

  initial begin
    rst         = 1'b1;
    frame_start = 1'b0;
    clear_state = 1'b0;
    layer_valid = '0;
    exp_frames  = '0;
    last_cyc    = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run_frame(1, -1, -1, 1'b0);   // minimum frame: 12 cycles
    run_frame(2, 2, -1, 1'b1);    // clear+start, plus requests while busy
    run_frame(3, -1, 1, 1'b0);    // spurious valid[4] during gru1

    do_timeout(3);
    run_frame(1, -1, -1, 1'b0);   // frame_start recovers from ERR

    do_timeout(4);
    clear_state = 1'b1;
    @(negedge clk);
    clear_state = 1'b0;
    chk("errclr_strobe", 32'(state_clear), 32'd1);
    chk("errclr_err", 32'(error), 32'd0);
    chk("errclr_errl", 32'(err_layer), 32'd0);
    @(negedge clk);
    chk("errclr_idle", 32'(dbg_state), 32'(rnn_pkg::S_IDLE));
    chk("errclr_start", 32'(layer_start), 32'd0);

    run_frame(4, -1, -1, 1'b0);   // 30 cycles, just below saturation

    launch(1'b0);
    serve_layer(0, 1, 1'b0, 1'b0);
    serve_layer(1, 1, 1'b0, 1'b0);
    chk("abort_k2", 32'(layer_start), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("abort");
    exp_frames = '0;
    last_cyc   = '0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_nodone", 32'(frame_done), 32'd0);
      chk("abort_nolatch", 32'(state_latch), 32'd0);
    end

    run_frame(1, -1, -1, 1'b0);
    run_frame(TO - 1, -1, -1, 1'b0);  // every valid coincides with expiry; saturates

    while (exp_frames != 4'd15) run_frame(1, -1, -1, 1'b0);
    run_frame(1, -1, -1, 1'b0);
    chk("count_wrap", 32'(frame_count), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rnn_layer_scheduler.md
# rnn_layer_scheduler

Frame-level sequencer for the denoise RNN datapath. Drives the six layer engines (dense1, gru1, dense2, gru2, gru3, dense3) strictly in order through a start/valid handshake, issues GRU-state latch strobes at the right points, and supervises each layer with a watchdog. It sits between the frame-input logic (feature buffer ready) and the layer engines, replacing ad-hoc start/valid glue in the top level.

## Interface
- NUM_LAYERS, 6: number of engines in the fixed order dense1, gru1, dense2, gru2, gru3, dense3 (indices 0..5).
- TIMEOUT_CYCLES, 65535: max cycles a layer may hold start without valid; 0 disables the watchdog.
- CNT_W, 16: width of the watchdog and frame-cycle counters.
- FRAME_CNT_W, 32: width of the frame counter.

Ports:
- clk  in  1  single clock; everything is synchronous to its rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle request to run one frame; honored only in IDLE or ERR.
- clear_state  in  1  request to zero all GRU states before the next frame; honored only in IDLE or ERR.
- layer_valid  in  NUM_LAYERS  per-engine completion pulse.
- layer_start  out  NUM_LAYERS  one-hot level; bit k stays high until layer_valid[k] is accepted.
- state_latch  out  3  one-cycle strobes: bit0 vad (gru1), bit1 noise (gru2), bit2 denoise (gru3) state registers capture.
- state_clear  out  1  one-cycle strobe zeroing all GRU state registers.
- busy  out  1  high from first layer_start until frame_done.
- frame_done  out  1  one-cycle pulse when dense3 completes.
- error  out  1  sticky watchdog error.
- err_layer  out  3  index of the layer that timed out; valid while error=1.
- frame_cycles  out  CNT_W  cycles of the last completed frame, saturating.
- frame_count  out  FRAME_CNT_W  completed frames, wraps.

## Operation
- States: IDLE, CLR, RUN (with layer index k), ERR.
- IDLE: on clear_state, go to CLR. On frame_start without clear_state, go to RUN with k=0.
- CLR: state_clear=1 for one cycle. If frame_start arrived with clear_state, latch it as pending. Then go to RUN k=0 if pending, else IDLE.
- RUN k: layer_start = 1<<k and the watchdog counts.
  - On layer_valid[k], drop start[k]. If k<5, go to RUN k+1. If k=5, pulse frame_done, increment frame_count, latch frame_cycles, go to IDLE.
  - Accepting valid for k=1, 3 or 4 pulses state_latch bit 0, 1 or 2 respectively.
- layer_valid bits other than k, and any valid outside RUN, are ignored.
- Watchdog: reloads to 0 on every layer transition. If it reaches TIMEOUT_CYCLES with no valid, all starts drop, error=1, err_layer=k, state goes to ERR. Valid arriving in the same cycle as the timeout wins and no error is raised.
- ERR: frame_start clears error and err_layer and starts at k=0. clear_state behaves as in IDLE and also clears error.
- frame_start while busy: ignored, not queued.
- frame_cycles saturates at 2^CNT_W-1. frame_count wraps to 0.
- Reset values: every output is 0, and the state is IDLE. rst mid-frame aborts immediately with no frame_done and no latch strobes.

## Timing
- frame_start at edge t (IDLE): layer_start[0]=1 from t+1.
- With clear_state at t: state_clear at t+1, layer_start[0] from t+2.
- layer_valid[k] sampled at t: layer_start[k]=0 and layer_start[k+1]=1 from t+1, so handoff costs one cycle. The state_latch strobe is high during t+1.
- layer_valid[5] at t: frame_done=1 and busy=0 during t+1.
- Minimum frame: each valid arrives one cycle after its start rises. frame_start at 0 gives frame_done at 13 and frame_cycles=12, counted from the first start cycle through the dense3 valid cycle inclusive.
- Timeout: start rises at s, no valid arrives, so error=1 at s+TIMEOUT_CYCLES.

## Structure
- Shared package rnn_pkg holds:
  - layer index constants L_DENSE1..L_DENSE3;
  - the scheduler state enum;
  - the GRU latch map (gru1→0, gru2→1, gru3→2);
  - FIXED=32 for datapath consumers.
- Sub-module rnn_layer_watchdog: CNT_W counter with clear, enable and timeout-compare output; also reused for frame_cycles with saturation.

## Test plan
- Reset, then frame_start; each engine's valid returns 1 cycle after its start → starts 0..5 one-hot in order, state_latch at cycles 5, 9, 11, frame_done at 13, frame_cycles=12, frame_count=1.
- frame_start with clear_state together → state_clear at t+1, start[0] at t+2. frame_start while busy → ignored, frame_count advances by only 1.
- TIMEOUT_CYCLES=20, gru2 never returns valid → error=1 and err_layer=3 exactly 20 cycles after start[3]; all starts 0. Next frame_start clears error and reruns the frame.
- Spurious layer_valid[4] while in RUN k=1 → no state change, no latch strobe.
- rst asserted during RUN k=2 → next cycle all outputs 0, no frame_done. A following frame_start runs normally from k=0.
- Valid coincident with watchdog expiry → transition taken, error stays 0. frame_count at 2^32-1 plus one frame → wraps to 0.
